// File: rtl/ir_nec_rx.sv
// NEC infrared remote receiver: synchronises the idle-high IR pin, times mark/space
// widths in microsecond ticks and reports frames, repeat codes and errors as pulses.
module ir_nec_rx #(
    parameter int TICK_DIV  = 50,
    parameter bit CHECK_INV = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ir_i,
    output logic [31:0] code_o,
    output logic        valid_o,
    output logic        repeat_o,
    output logic        error_o,
    output logic        busy_o
);
    localparam int          PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] TIMEOUT = 16'd10001;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_RPT_MARK
    } state_t;

    state_t        r_state, w_state_n;
    logic          r_sync1, r_sync2, r_sync3;
    logic          r_fall, r_rise;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_width;
    logic [31:0]   r_shift, r_code;
    logic [4:0]    r_cnt;
    logic          r_valid, r_repeat, r_error;
    logic          w_tick, w_edge, w_check;
    logic          w_ok, w_rpt, w_err, w_start, w_shift, w_bit;

    function automatic logic in_win(input logic [15:0] w, input logic [15:0] lo, input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    assign w_tick  = (r_pre == PW'(TICK_DIV - 1));
    assign w_edge  = r_fall | r_rise;
    assign w_check = (r_shift[31:24] == ~r_shift[23:16]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_ok      = 1'b0;
        w_rpt     = 1'b0;
        w_err     = 1'b0;
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_bit     = 1'b0;
        case (r_state)
            S_IDLE: if (r_fall) w_state_n = S_LEAD_MARK;
            S_LEAD_MARK: if (r_rise) begin
                if (in_win(r_width, 16'd8000, 16'd10000)) w_state_n = S_LEAD_SPACE;
                else                                      w_err = 1'b1;
            end
            S_LEAD_SPACE: if (r_fall) begin
                if (in_win(r_width, 16'd4000, 16'd5000)) begin
                    w_state_n = S_BIT_MARK;
                    w_start   = 1'b1;
                end else if (in_win(r_width, 16'd1800, 16'd2700)) begin
                    w_state_n = S_RPT_MARK;
                end else begin
                    w_err = 1'b1;
                end
            end
            S_BIT_MARK: if (r_rise) begin
                if (in_win(r_width, 16'd300, 16'd900)) w_state_n = S_BIT_SPACE;
                else                                   w_err = 1'b1;
            end
            S_BIT_SPACE: if (r_fall) begin
                if (in_win(r_width, 16'd300, 16'd900)) begin
                    w_shift = 1'b1;
                end else if (in_win(r_width, 16'd1300, 16'd2000)) begin
                    w_shift = 1'b1;
                    w_bit   = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
                if (w_shift) w_state_n = (r_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            end
            S_STOP_MARK: if (r_rise) begin
                // final bit is already in r_shift, so the command check sees the whole frame
                if (in_win(r_width, 16'd300, 16'd900) && (!CHECK_INV || w_check)) begin
                    w_ok      = 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_err = 1'b1;
                end
            end
            S_RPT_MARK: if (r_rise) begin
                if (in_win(r_width, 16'd300, 16'd900)) begin
                    w_rpt     = 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_err = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        // an edge in the same cycle takes precedence over the timeout
        if (r_state != S_IDLE && !w_edge && r_width == TIMEOUT) w_err = 1'b1;
        if (w_err) w_state_n = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync3  <= 1'b1;
            r_fall   <= 1'b0;
            r_rise   <= 1'b0;
            r_pre    <= '0;
            r_width  <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_repeat <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_sync1  <= ir_i;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_fall   <= r_sync3 & ~r_sync2;
            r_rise   <= ~r_sync3 & r_sync2;
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            if (w_edge)                          r_width <= '0;
            else if (w_tick && r_width != 16'hFFFF) r_width <= r_width + 16'd1;
            if (w_start) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift) begin
                r_shift[r_cnt] <= w_bit;
                r_cnt          <= r_cnt + 5'd1;
            end
            if (w_ok) r_code <= r_shift;
            r_valid  <= w_ok;
            r_repeat <= w_rpt;
            r_error  <= w_err;
        end
    end

    assign code_o   = r_code;
    assign valid_o  = r_valid;
    assign repeat_o = r_repeat;
    assign error_o  = r_error;
    assign busy_o   = (r_state != S_IDLE);
endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx: two instances (command check on/off) share one IR line,
// timed with one tick per clock so every microsecond is a single cycle.
module tb_ir_nec_rx;
    localparam int M  = 310;
    localparam int S0 = 310;
    localparam int S1 = 1310;
    localparam int LM = 8010;
    localparam int LS = 4010;
    localparam int RS = 1810;
    localparam logic [31:0] FA = 32'h5DA2FF00;
    localparam logic [31:0] FB = 32'h5CA2FF00;

    logic        clk = 1'b0, rst = 1'b1, ir = 1'b1;
    logic [31:0] code0, code1;
    logic        v0, r0, e0, b0, v1, r1, e1, b1;

    int nvec = 0, nerr = 0;
    int cv0 = 0, cr0 = 0, ce0 = 0, cv1 = 0, cr1 = 0, ce1 = 0, ovl = 0;
    int bv0, br0, be0, bv1, br1, be1;
    int k;

    always #5 clk = ~clk;

    ir_nec_rx #(.TICK_DIV(1), .CHECK_INV(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst), .ir_i(ir), .code_o(code0),
        .valid_o(v0), .repeat_o(r0), .error_o(e0), .busy_o(b0));
    ir_nec_rx #(.TICK_DIV(1), .CHECK_INV(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst), .ir_i(ir), .code_o(code1),
        .valid_o(v1), .repeat_o(r1), .error_o(e1), .busy_o(b1));

    always @(negedge clk) begin
        if (!rst) begin
            cv0 = cv0 + int'(v0); cr0 = cr0 + int'(r0); ce0 = ce0 + int'(e0);
            cv1 = cv1 + int'(v1); cr1 = cr1 + int'(r1); ce1 = ce1 + int'(e1);
            if ((int'(v0) + int'(r0) + int'(e0)) > 1 || (int'(v1) + int'(r1) + int'(e1)) > 1)
                ovl = ovl + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic level(input logic v, input int n);
        ir = v;
        repeat (n) @(negedge clk);
    endtask

    // lead + nbits of mark/space (space of bit 'bad' stretched to 1100), optional trailing mark
    task automatic send(input logic [31:0] c, input int nbits, input int bad, input bit stop);
        level(1'b0, LM);
        level(1'b1, LS);
        for (int i = 0; i < nbits; i++) begin
            level(1'b0, M);
            level(1'b1, (i == bad) ? 1100 : (c[i] ? S1 : S0));
        end
        if (stop) level(1'b0, M);
    endtask

    task automatic snap();
        bv0 = cv0; br0 = cr0; be0 = ce0;
        bv1 = cv1; br1 = cr1; be1 = ce1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst code0", code0, 32'h0);
        check("rst code1", code1, 32'h0);
        check("rst valid", {31'h0, v0 | v1}, 32'h0);
        check("rst pulses", {30'h0, r0 | r1, e0 | e1}, 32'h0);
        check("rst busy", {31'h0, b0 | b1}, 32'h0);
        rst = 1'b0;
        level(1'b1, 20);

        snap();
        send(FA, 32, -1, 1'b1);
        level(1'b1, 50);
        check("A valid0", cv0 - bv0, 1);
        check("A code0", code0, FA);
        check("A valid1", cv1 - bv1, 1);
        check("A code1", code1, FA);
        check("A err0", ce0 - be0, 0);
        check("A busy", {31'h0, b0}, 32'h0);

        snap();
        level(1'b0, LM);
        level(1'b1, RS);
        level(1'b0, M);
        level(1'b1, 50);
        check("RPT repeat0", cr0 - br0, 1);
        check("RPT repeat1", cr1 - br1, 1);
        check("RPT valid0", cv0 - bv0, 0);
        check("RPT code0", code0, FA);

        snap();
        send(FB, 32, -1, 1'b1);
        level(1'b1, 50);
        check("B err0", ce0 - be0, 1);
        check("B valid0", cv0 - bv0, 0);
        check("B code0", code0, FA);
        check("B valid1", cv1 - bv1, 1);
        check("B code1", code1, FB);

        snap();
        send(FA, 12, -1, 1'b1);
        ir = 1'b1;
        k = 0;
        while (e0 !== 1'b1 && k < 12000) begin
            @(negedge clk);
            k++;
        end
        check("TO latency", {31'h0, (k >= 10003 && k <= 10009)}, 32'h1);
        level(1'b1, 20);
        check("TO err0", ce0 - be0, 1);
        check("TO err1", ce1 - be1, 1);
        check("TO busy", {31'h0, b0}, 32'h0);

        snap();
        level(1'b0, 7000);
        level(1'b1, 50);
        check("LEAD7000 err0", ce0 - be0, 1);
        check("LEAD7000 busy", {31'h0, b0}, 32'h0);

        snap();
        send(FA, 5, 4, 1'b1);
        level(1'b1, 50);
        check("SP1100 err0", ce0 - be0, 1);
        check("SP1100 err1", ce1 - be1, 1);
        check("SP1100 valid", cv0 - bv0, 0);

        send(FA, 20, -1, 1'b0);
        level(1'b0, 100);
        rst = 1'b1;
        @(negedge clk);
        check("MIDRST code0", code0, 32'h0);
        check("MIDRST code1", code1, 32'h0);
        check("MIDRST flags", {28'h0, v0, r0, e0, b0}, 32'h0);
        level(1'b0, 100);
        level(1'b1, 20);
        rst = 1'b0;
        level(1'b1, 20);

        snap();
        send(FA, 32, -1, 1'b1);
        level(1'b1, 50);
        check("POST valid0", cv0 - bv0, 1);
        check("POST code0", code0, FA);
        check("POST valid1", cv1 - bv1, 1);
        check("POST code1", code1, FA);
        check("POST err0", ce0 - be0, 0);
        check("overlap pulses", ovl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
